// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg: shared types and helpers for sync_ram_clr.
// Contents: state_t {CLEAR, READY}, clog2() address-width helper,
// even_par() parity over a vector zero-extended to MAX_W bits.
package sync_ram_pkg;
   typedef enum logic {CLEAR, READY} state_t;
   localparam int MAX_W = 256;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   // Zero-extension leaves the XOR unchanged, so callers cast narrower words up.
   function automatic logic even_par(input logic [MAX_W-1:0] v);
      return ^v;
   endfunction
endpackage

// File: rtl/sync_ram_clr_seq.sv
// sync_ram_clr_seq: clear sequencer, owns state, sweep counter, busy and the array write-port mux.
// Ports: clock, reset (async, active-high), clear (start sweep, sampled in READY),
//        port_we/port_addr/port_word (qualified user write), mem_we/mem_addr/mem_word (to array),
//        ready (state is READY), busy (registered, high during sweep).
module sync_ram_clr_seq import sync_ram_pkg::*; #(
   parameter  int            DEPTH    = 8,
   parameter  int            MW       = 8,
   parameter  logic [MW-1:0] CLR_WORD = '0,
   localparam int            ADDR_W   = clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              port_we,
   input  logic [ADDR_W-1:0] port_addr,
   input  logic [MW-1:0]     port_word,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [MW-1:0]     mem_word,
   output logic              ready,
   output logic              busy
);
   state_t            state;
   logic [ADDR_W-1:0] cnt;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (state == CLEAR) begin
         if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            cnt   <= '0;
            busy  <= 1'b0;
         end else cnt <= cnt + 1'b1;
      end else if (clear) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end
   assign ready = (state == READY);
   // Port writes are only qualified in READY, so the two sources never collide.
   always_comb begin
      mem_we   = ready ? port_we : 1'b1;
      mem_addr = ready ? port_addr : cnt;
      mem_word = ready ? port_word : CLR_WORD;
   end
endmodule

// File: rtl/sync_ram_clr.sv
// sync_ram_clr: single-clock RAM, separate write/read ports, registered 1-cycle read, built-in clear sweep.
// Ports: clock, reset (async, active-high), clear, wr_en/wr_addr/wr_data, rd_en/rd_addr,
//        rd_data/rd_valid (registered read result), busy (sweep in progress, accesses ignored).
// Option: define SYNC_RAM_PARITY_EN to store an even-parity bit per word, adding input
//        wr_par_inj (invert stored parity on accepted write) and output rd_perr (valid with rd_valid).
module sync_ram_clr import sync_ram_pkg::*; #(
   parameter  int                DATA_W    = 8,
   parameter  int                DEPTH     = 8,
   parameter  logic [DATA_W-1:0] CLEAR_VAL = '0,
   localparam int                ADDR_W    = clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
`ifdef SYNC_RAM_PARITY_EN
   input  logic              wr_par_inj,
   output logic              rd_perr,
`endif
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy
);
`ifdef SYNC_RAM_PARITY_EN
   localparam int MW = DATA_W + 1;
   localparam logic [MW-1:0] CLR_WORD = {even_par(MAX_W'(CLEAR_VAL)), CLEAR_VAL};
   logic [MW-1:0] port_word;
   assign port_word = {even_par(MAX_W'(wr_data)) ^ wr_par_inj, wr_data};
`else
   localparam int MW = DATA_W;
   localparam logic [MW-1:0] CLR_WORD = CLEAR_VAL;
   logic [MW-1:0] port_word;
   assign port_word = wr_data;
`endif
   logic [MW-1:0]     mem [DEPTH];
   logic              ready, wr_acc, rd_acc, rd_in, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [MW-1:0]     mem_word, rd_word;
   assign wr_acc = ready & wr_en & ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
   assign rd_acc = ready & rd_en;
   assign rd_in  = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);
   // Write-first: a same-cycle write to the read address is forwarded.
   assign rd_word = (wr_acc && wr_addr == rd_addr) ? port_word : mem[rd_addr];
   sync_ram_clr_seq #(.DEPTH(DEPTH), .MW(MW), .CLR_WORD(CLR_WORD)) u_seq (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .port_we   (wr_acc),
      .port_addr (wr_addr),
      .port_word (port_word),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_word  (mem_word),
      .ready     (ready),
      .busy      (busy)
   );
   always_ff @(posedge clock)
      if (mem_we) mem[mem_addr] <= mem_word;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
`ifdef SYNC_RAM_PARITY_EN
         rd_perr  <= 1'b0;
`endif
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= rd_in ? rd_word[DATA_W-1:0] : '0;
`ifdef SYNC_RAM_PARITY_EN
            rd_perr <= rd_in & (^rd_word);
`endif
         end
      end
endmodule

// File: tb/tb_sync_ram_clr.sv
// tb_sync_ram_clr: directed self-checking bench for sync_ram_clr (DEPTH=8 and DEPTH=6 instances).
module tb_sync_ram_clr;
   logic       clock = 1'b0, reset = 1'b1, clear = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, wr_par_inj = 1'b0;
   logic [2:0] wr_addr = '0, rd_addr = '0;
   logic [7:0] wr_data = '0, rd_data;
   logic       rd_valid, busy, rd_perr;
   logic       wr_en6 = 1'b0, rd_en6 = 1'b0;
   logic [2:0] wr_addr6 = '0, rd_addr6 = '0;
   logic [7:0] wr_data6 = '0, rd_data6;
   logic       rd_valid6, busy6, rd_perr6;
   int total = 0, bad = 0;
   always #5 clock = ~clock;
   sync_ram_clr #(.DATA_W(8), .DEPTH(8), .CLEAR_VAL(8'h00)) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef SYNC_RAM_PARITY_EN
      .wr_par_inj(wr_par_inj), .rd_perr(rd_perr),
`endif
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
   );
   sync_ram_clr #(.DATA_W(8), .DEPTH(6), .CLEAR_VAL(8'h00)) dut6 (
      .clock(clock), .reset(reset), .clear(1'b0),
      .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
      .rd_en(rd_en6), .rd_addr(rd_addr6),
`ifdef SYNC_RAM_PARITY_EN
      .wr_par_inj(1'b0), .rd_perr(rd_perr6),
`endif
      .rd_data(rd_data6), .rd_valid(rd_valid6), .busy(busy6)
   );
`ifndef SYNC_RAM_PARITY_EN
   assign rd_perr  = 1'b0;
   assign rd_perr6 = 1'b0;
`endif
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask
   task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
      rd_en = 1'b1; rd_addr = a;
      step();
      rd_en = 1'b0;
      chk({tag, "_valid"}, {7'd0, rd_valid}, 8'd1);
      chk({tag, "_data"}, rd_data, exp);
   endtask
   task automatic sweep_chk(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk(tag, {7'd0, busy}, 8'd1);
         step();
      end
      chk({tag, "_end"}, {7'd0, busy}, 8'd0);
   endtask
   initial begin
      step();
      step();
      chk("rst_busy", {7'd0, busy}, 8'd1);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rd_valid", {7'd0, rd_valid}, 8'd0);
      chk("rst_busy6", {7'd0, busy6}, 8'd1);
      reset = 1'b0;
      sweep_chk("init_sweep");
      chk("init_busy6", {7'd0, busy6}, 8'd0);
      for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "init_rd");
      step();
      chk("idle_valid", {7'd0, rd_valid}, 8'd0);
      chk("idle_hold", rd_data, 8'h00);
      wr(3'd3, 8'hA5);
      rd(3'd3, 8'hA5, "wr_rd3");
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
      rd_en = 1'b1; rd_addr = 3'd5;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("wf_valid", {7'd0, rd_valid}, 8'd1);
      chk("wf_data", rd_data, 8'h3C);
      rd(3'd5, 8'h3C, "wf_stored");
      rd(3'd3, 8'hA5, "rd3_kept");
      wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 8'hFF;
      step();
      wr_addr6 = 3'd6;
      step();
      wr_en6 = 1'b0;
      rd_en6 = 1'b1; rd_addr6 = 3'd7;
      step();
      chk("oor7_valid", {7'd0, rd_valid6}, 8'd1);
      chk("oor7_data", rd_data6, 8'h00);
      rd_addr6 = 3'd6;
      step();
      chk("oor6_data", rd_data6, 8'h00);
      rd_addr6 = 3'd5;
      step();
      rd_en6 = 1'b0;
      chk("d6_a5_valid", {7'd0, rd_valid6}, 8'd1);
      chk("d6_a5_data", rd_data6, 8'h00);
      for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h11 * (i + 1)));
      rd(3'd2, 8'h33, "fill_rd2");
      rd(3'd7, 8'h88, "fill_rd7");
      clear = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h99;
      rd_en = 1'b1; rd_addr = 3'd0;
      step();
      clear = 1'b0;
      chk("clr_busy0", {7'd0, busy}, 8'd1);
      chk("clr_same_valid", {7'd0, rd_valid}, 8'd1);
      chk("clr_same_data", rd_data, 8'h99);
      wr_data = 8'h55; rd_addr = 3'd1;
      for (int i = 1; i < 8; i++) begin
         step();
         chk("clr_busy", {7'd0, busy}, 8'd1);
         chk("clr_no_valid", {7'd0, rd_valid}, 8'd0);
         chk("clr_hold", rd_data, 8'h99);
      end
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("clr_done", {7'd0, busy}, 8'd0);
      chk("clr_done_valid", {7'd0, rd_valid}, 8'd0);
      for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "post_clr_rd");
      wr(3'd6, 8'h66);
      rd(3'd6, 8'h66, "pre_rst_rd6");
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", {7'd0, busy}, 8'd1);
      chk("mid_rst_data", rd_data, 8'h00);
      chk("mid_rst_valid", {7'd0, rd_valid}, 8'd0);
      rd_en = 1'b1; rd_addr = 3'd6;
      step();
      chk("in_rst_valid", {7'd0, rd_valid}, 8'd0);
      rd_en = 1'b0;
      reset = 1'b0;
      sweep_chk("resweep");
      rd(3'd6, 8'h00, "resweep_rd6");
      rd(3'd0, 8'h00, "resweep_rd0");
`ifdef SYNC_RAM_PARITY_EN
      wr_par_inj = 1'b1;
      wr(3'd2, 8'h07);
      wr_par_inj = 1'b0;
      rd(3'd2, 8'h07, "par_inj");
      chk("par_inj_perr", {7'd0, rd_perr}, 8'd1);
      wr(3'd2, 8'h07);
      rd(3'd2, 8'h07, "par_ok");
      chk("par_ok_perr", {7'd0, rd_perr}, 8'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
